// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase accumulator slice.
package dds_pkg;

  // Quadrant encoding of the two top phase address bits.
  localparam logic [1:0] QuadRise = 2'b00;  // 0 .. pi/2
  localparam logic [1:0] QuadFall = 2'b01;  // pi/2 .. pi
  localparam logic [1:0] QuadNegF = 2'b10;  // pi .. 3pi/2
  localparam logic [1:0] QuadNegR = 2'b11;  // 3pi/2 .. 2pi

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPend
  } state_e;

  // Offset-binary zero level for an out_w-bit sample.
  function automatic int unsigned midscale(input int unsigned out_w);
    return 32'd1 << (out_w - 1);
  endfunction

endpackage

// File: rtl/dds_phase_accum_if.sv
// Tuning-word handshake and sample output bundle of the DDS core.
interface dds_phase_accum_if #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 8
) ();

  logic [ACC_W-1:0] ftw_in;
  logic             ftw_valid;
  logic             ftw_ready;
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             wrap;

  modport master (
    output ftw_in,
    output ftw_valid,
    input  ftw_ready,
    input  sample_out,
    input  sample_valid,
    input  wrap
  );

  modport slave (
    input  ftw_in,
    input  ftw_valid,
    output ftw_ready,
    output sample_out,
    output sample_valid,
    output wrap
  );

endinterface

// File: rtl/dds_sine_lut.sv
// Registered quarter-wave sine ROM; contents computed at elaboration.
module dds_sine_lut #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam real HalfPi = 1.5707963267948966;
  localparam real Amp = real'((1 << DATA_W) - 1);

  logic [DATA_W-1:0] rom [Depth];

  for (genvar k = 0; k < Depth; k++) begin : g_rom
    localparam int Val = $rtoi(Amp * $sin(HalfPi * real'(k) / real'(Depth)) + 0.5);
    assign rom[k] = DATA_W'(Val);
  end

  // Read port: loads only when a new sample is moving through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (en) begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: FTW handshake FSM, accumulator, 3-stage sine pipeline.
// Optional feature: define DDS_PHASE_DITHER_EN to add LFSR phase dither to the
// LUT address (the accumulator itself is never dithered).
module dds_phase_accum
  import dds_pkg::*;
#(
  parameter int unsigned      ACC_W       = 32,
  parameter int unsigned      PHASE_W     = 10,
  parameter int unsigned      OUT_W       = 8,
  parameter logic [ACC_W-1:0] FTW_DEFAULT = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_offset,
  dds_phase_accum_if.slave   bus
);

  localparam logic [OUT_W-1:0] Mid = OUT_W'(midscale(OUT_W));
  localparam int unsigned IdxW = PHASE_W - 2;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] ftw_q, ftw_d, pend_q, pend_d;
  logic [ACC_W-1:0] ftw_eff;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   acc_sum;
  logic             handshake, adv;
  logic             v1_q, v2_q, valid_q;
  logic             wrap1_q, wrap2_q, wrap_q;
  logic [PHASE_W-1:0] addr_q, addr_d;
  logic [1:0]       quad;
  logic [IdxW-1:0]  lut_idx;
  logic [OUT_W-2:0] mag;
  logic             neg_q;
  logic             dither_carry;

  assign handshake     = bus.ftw_valid && bus.ftw_ready;
  assign bus.ftw_ready = (state_q != StPend);
  // Ticks only count while enabled and the FSM has left IDLE.
  assign adv           = sample_tick && enable && (state_q != StIdle);
  // A pending word takes effect on the very tick that retires it.
  assign ftw_eff       = (state_q == StPend) ? pend_q : ftw_q;
  assign acc_sum       = {1'b0, acc_q} + {1'b0, ftw_eff};

  // FSM and tuning-word registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ftw_q   <= FTW_DEFAULT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state: IDLE loads directly, RUN defers the word to the next tick.
  always_comb begin
    state_d = state_q;
    ftw_d   = ftw_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) ftw_d = bus.ftw_in;
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
          if (handshake) ftw_d = bus.ftw_in;
        end else if (handshake) begin
          pend_d  = bus.ftw_in;
          state_d = StPend;
        end
      end
      StPend: begin
        if (!enable || adv) begin
          ftw_d   = pend_q;
          state_d = enable ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: accumulate once per tick, capturing the carry out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      wrap1_q <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= adv;
      if (adv) begin
        acc_q   <= acc_sum[ACC_W-1:0];
        wrap1_q <= acc_sum[ACC_W];
      end
    end
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam int unsigned LowW    = ACC_W - PHASE_W;
  localparam int unsigned DitherW = (LowW < 16) ? LowW : 16;

  logic [15:0]  lfsr_q;
  logic [LowW:0] low_sum;

  // Galois LFSR, taps 16,14,13,11, stepped once per accepted tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else if (adv) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign low_sum      = {1'b0, acc_q[LowW-1:0]} + (LowW + 1)'(lfsr_q[DitherW-1:0]);
  assign dither_carry = low_sum[LowW];
`else
  assign dither_carry = 1'b0;
`endif

  assign addr_d = acc_q[ACC_W-1 -: PHASE_W] + PHASE_W'(dither_carry) + phase_offset;

  // Stage 2: phase address (offset sampled every cycle).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      v2_q    <= 1'b0;
      wrap2_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      v2_q    <= v1_q;
      wrap2_q <= v1_q && wrap1_q;
    end
  end

  assign quad    = addr_q[PHASE_W-1 -: 2];
  assign lut_idx = (quad == QuadFall || quad == QuadNegR) ? ~addr_q[IdxW-1:0]
                                                          : addr_q[IdxW-1:0];

  dds_sine_lut #(
    .ADDR_W(IdxW),
    .DATA_W(OUT_W - 1)
  ) u_lut (
    .clock(clock),
    .reset(reset),
    .en   (v2_q),
    .addr (lut_idx),
    .data (mag)
  );

  // Stage 3: sign, valid and wrap travel alongside the ROM read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      valid_q <= v2_q;
      wrap_q  <= v2_q && wrap2_q;
      if (v2_q) neg_q <= (quad == QuadNegF || quad == QuadNegR);
    end
  end

  assign bus.sample_out   = neg_q ? (Mid - {1'b0, mag}) : (Mid + {1'b0, mag});
  assign bus.sample_valid = valid_q;
  assign bus.wrap         = wrap_q;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Self-checking bench for dds_phase_accum (ACC_W=32, PHASE_W=10, OUT_W=8).
module tb_dds_phase_accum;

  logic       clock;
  logic       reset;
  logic       sample_tick;
  logic       enable;
  logic [9:0] phase_offset;

  dds_phase_accum_if #(.ACC_W(32), .OUT_W(8)) bus ();

  dds_phase_accum #(
    .ACC_W      (32),
    .PHASE_W    (10),
    .OUT_W      (8),
    .FTW_DEFAULT(32'd0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_tick (sample_tick),
    .enable      (enable),
    .phase_offset(phase_offset),
    .bus         (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int failed = 0;

  // Reference state: what the block should hold, by the rules of the datasheet.
  logic [31:0] m_acc;
  logic [31:0] m_ftw;
  logic [31:0] m_pend;
  bit          m_pend_v;
  bit          m_run;
  logic [9:0]  m_off;
  longint      sample_sum;
  int          sample_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal full-wave sine of the top 10 phase bits plus offset, in offset binary.
  function automatic logic [7:0] ref_sample(input logic [31:0] acc, input logic [9:0] off);
    int  a, q, i, k, mag;
    real ang;
    a = int'(((acc >> 22) + 32'(off)) & 32'd1023);
    q = a / 256;
    i = a % 256;
    k = (q == 1 || q == 3) ? 255 - i : i;
    ang = 3.14159265358979 / 2.0 * real'(k) / 256.0;
    mag = $rtoi(127.0 * $sin(ang) + 0.5);
    return (q < 2) ? 8'(128 + mag) : 8'(128 - mag);
  endfunction

  task automatic model_reset();
    m_acc = '0; m_ftw = '0; m_pend = '0; m_pend_v = 0; m_run = 0;
  endtask

  task automatic set_enable(input bit b);
    enable = b;
    if (!b && m_pend_v) begin
      m_ftw = m_pend;
      m_pend_v = 0;
    end
    m_run = b;
    repeat (2) @(negedge clock);
  endtask

  // Handshake without a tick.
  task automatic load_ftw(input logic [31:0] word);
    bus.ftw_in = word;
    bus.ftw_valid = 1'b1;
    @(negedge clock);
    bus.ftw_valid = 1'b0;
    if (!m_pend_v) begin
      if (m_run) begin
        m_pend = word;
        m_pend_v = 1;
      end else begin
        m_ftw = word;
      end
    end
    check("ftw_ready_after_load", 32'(bus.ftw_ready), 32'(!m_pend_v));
  endtask

  // One tick, optional simultaneous handshake, optional offset change
  // (off_when 1: one clock after the tick, 2: two clocks after).
  task automatic tick(input bit hs, input logic [31:0] word, input int off_when,
                      input logic [9:0] off_new);
    logic [32:0] s;
    logic [9:0]  use_off;
    bit          hs_ok;
    logic [7:0]  exp_s;
    bit          exp_w;
    sample_tick = 1'b1;
    bus.ftw_valid = hs;
    bus.ftw_in = word;
    @(negedge clock);
    sample_tick = 1'b0;
    bus.ftw_valid = 1'b0;
    hs_ok = hs && !m_pend_v;
    exp_w = 0;
    exp_s = 8'd128;
    if (m_run) begin
      if (m_pend_v) begin
        m_ftw = m_pend;
        m_pend_v = 0;
      end
      s = {1'b0, m_acc} + {1'b0, m_ftw};
      m_acc = s[31:0];
      exp_w = s[32];
      if (hs_ok) begin
        m_pend = word;
        m_pend_v = 1;
      end
    end else if (hs_ok) begin
      m_ftw = word;
    end
    use_off = (off_when == 1) ? off_new : m_off;
    exp_s = ref_sample(m_acc, use_off);
    if (off_when == 1) phase_offset = off_new;
    @(negedge clock);
    check("valid_not_early", 32'(bus.sample_valid), 32'd0);
    if (off_when == 2) phase_offset = off_new;
    @(negedge clock);
    if (m_run) begin
      check("valid_at_3", 32'(bus.sample_valid), 32'd1);
      check("wrap", 32'(bus.wrap), 32'(exp_w));
`ifndef DDS_PHASE_DITHER_EN
      check("sample", 32'(bus.sample_out), 32'(exp_s));
`endif
      sample_sum += longint'(bus.sample_out);
      sample_cnt++;
    end else begin
      check("valid_idle", 32'(bus.sample_valid), 32'd0);
    end
    @(negedge clock);
    check("valid_one_cycle", 32'(bus.sample_valid), 32'd0);
    check("ftw_ready", 32'(bus.ftw_ready), 32'(!m_pend_v));
    if (off_when != 0) m_off = off_new;
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    sample_tick = 1'b0;
    enable = 1'b0;
    phase_offset = '0;
    bus.ftw_in = '0;
    bus.ftw_valid = 1'b0;
    m_off = '0;
    sample_sum = 0;
    sample_cnt = 0;
    model_reset();
    #1;
    check("rst_sample", 32'(bus.sample_out), 32'd128);
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_ready", 32'(bus.ftw_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset mid-run with a pending word and a sample in flight.
    load_ftw(32'h4000_0000);
    set_enable(1);
    tick(0, 0, 0, 0);
    load_ftw(32'h0040_0000);
    sample_tick = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sample", 32'(bus.sample_out), 32'd128);
    check("async_rst_valid", 32'(bus.sample_valid), 32'd0);
    check("async_rst_wrap", 32'(bus.wrap), 32'd0);
    check("async_rst_ready", 32'(bus.ftw_ready), 32'd1);
    sample_tick = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);

    // Default ftw is zero: samples keep pulsing at midscale, never wrapping.
    set_enable(1);
    repeat (3) tick(0, 0, 0, 0);

    // One full sine period at ftw = 2^22.
    set_enable(0);
    load_ftw(32'h0040_0000);
    set_enable(1);
    for (int i = 0; i < 1024; i++) tick(0, 0, 0, 0);

    // Nyquist rate with a quarter-wave offset.
    set_enable(0);
    load_ftw(32'h8000_0000);
    phase_offset = 10'd256;
    m_off = 10'd256;
    set_enable(1);
    repeat (6) tick(0, 0, 0, 0);

    // Handshake coincident with a tick while running.
    set_enable(0);
    phase_offset = '0;
    m_off = '0;
    load_ftw(32'h0040_0000);
    set_enable(1);
    repeat (2) tick(0, 0, 0, 0);
    tick(1, 32'h0080_0000, 0, 0);
    load_ftw(32'h1234_5678);  // held off while pending
    repeat (3) tick(0, 0, 0, 0);

    // Hold phase while disabled, then resume; offset timing.
    set_enable(0);
    for (int i = 0; i < 50; i++) tick(0, 0, 0, 0);
    set_enable(1);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 10'(300));
    tick(0, 0, 2, 10'(77));
    tick(0, 0, 0, 0);

    // Pending word applied immediately when enable drops.
    load_ftw(32'h0100_0000);
    set_enable(0);
    check("ready_after_disable", 32'(bus.ftw_ready), 32'd1);
    set_enable(1);
    tick(0, 0, 0, 0);

    // Randomised mix of words, handshakes, offsets and enables.
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      case ($urandom_range(0, 9))
        0: load_ftw(w);
        1: set_enable(!m_run);
        2: tick(1, w, 0, 0);
        3: tick(0, 0, int'($urandom_range(1, 2)), 10'($urandom));
        default: tick(0, 0, 0, 0);
      endcase
    end

`ifdef DDS_PHASE_DITHER_EN
    set_enable(0);
    phase_offset = '0;
    m_off = '0;
    load_ftw(32'h0060_0000);
    set_enable(1);
    sample_sum = 0;
    sample_cnt = 0;
    for (int i = 0; i < 2048; i++) tick(0, 0, 0, 0);
    check("dither_mean_ok",
          32'(((sample_sum - 128 * longint'(sample_cnt)) <= longint'(sample_cnt)) &&
              ((128 * longint'(sample_cnt) - sample_sum) <= longint'(sample_cnt))), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
